// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, lock FSM encoding and CRC-16-CCITT constants for the VGA capture path
package vga_pkg;
  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int RGB_W = 12;
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} lock_t;
endpackage

// File: rtl/vga_crc16.sv
// vga_crc16: CRC-16-CCITT register absorbing one 12-bit pixel MSB-first per enabled cycle
module vga_crc16 import vga_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic [RGB_W-1:0] data,
  output logic [15:0]      crc
);
  logic [15:0] nxt;
  always_comb begin
    nxt = crc;
    for (int i = RGB_W - 1; i >= 0; i--)
      nxt = {nxt[14:0], 1'b0} ^ ((nxt[15] ^ data[i]) ? CRC_POLY : 16'h0000);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= CRC_INIT;
    else crc <= init ? CRC_INIT : en ? nxt : crc;
endmodule

// File: rtl/vga_capture.sv
// vga_capture: pixel capture, line/frame measurement and SEARCH/VERIFY/LOCKED lock tracking
// Define VGA_CAPTURE_CRC_EN to add a per-frame CRC-16-CCITT on frame_crc/crc_valid.
module vga_capture import vga_pkg::*; #(
  parameter int   H_ACTIVE = 640,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             reset,
  input  logic             clk_dot,
  input  logic [RGB_W-1:0] vga_pixel_rgb,
  input  logic             vga_active,
  input  logic             vga_hsync,
  input  logic             vga_vsync,
  output logic             pix_valid,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic [RGB_W-1:0] pix_rgb,
  output logic             frame_start,
  output logic [X_W-1:0]   meas_h,
  output logic [Y_W-1:0]   meas_v,
  output logic             locked,
  output logic             lock_err,
  output logic [15:0]      frame_crc,
  output logic             crc_valid
);
  logic [RGB_W-1:0] s1_rgb, s2_rgb;
  logic s1_act, s2_act, s1_hs, s2_hs, s1_vs, s2_vs;
  logic [X_W-1:0] col, width;
  logic [Y_W-1:0] row;
  logic skip, flag, rise, fall, hs_edge, vs_edge, line_end, line_bad;
  lock_t state, next_state;
  assign rise = s1_act & ~s2_act;
  assign fall = s2_act & ~s1_act;
  assign hs_edge = s1_hs & ~s2_hs;
  assign vs_edge = s1_vs & ~s2_vs;
  assign line_end = fall & ~skip;
  assign width = (col == X_MAX) ? col : col + 1'b1;
  assign line_bad = (line_end & (width != X_W'(H_ACTIVE))) | (hs_edge & s1_act);
  // col is the column of the pixel currently held in S2; skip marks a line cut by vsync
  always_ff @(posedge clk_dot or posedge reset)
    if (reset) begin
      {s1_rgb, s1_act, s1_hs, s1_vs, s2_rgb, s2_act, s2_hs, s2_vs} <= '0;
      {col, row, skip, flag, meas_h, meas_v} <= '0;
      {pix_valid, pix_x, pix_y, pix_rgb, frame_start} <= '0;
    end else begin
      s1_rgb <= vga_pixel_rgb;
      s1_act <= vga_active;
      s1_hs <= vga_hsync ~^ SYNC_POL;
      s1_vs <= vga_vsync ~^ SYNC_POL;
      {s2_rgb, s2_act, s2_hs, s2_vs} <= {s1_rgb, s1_act, s1_hs, s1_vs};
      col <= (rise | vs_edge) ? '0 : (s2_act && col != X_MAX) ? col + 1'b1 : col;
      skip <= vs_edge ? s2_act : rise ? 1'b0 : skip;
      row <= vs_edge ? '0 : (line_end && row != Y_MAX) ? row + 1'b1 : row;
      flag <= vs_edge ? 1'b0 : flag | line_bad;
      meas_h <= line_end ? width : meas_h;
      meas_v <= vs_edge ? row : meas_v;
      pix_valid <= s2_act;
      pix_x <= col;
      pix_y <= vs_edge ? '0 : row;
      pix_rgb <= s2_rgb;
      frame_start <= vs_edge;
    end
  always_ff @(posedge clk_dot or posedge reset)
    if (reset) begin
      state <= SEARCH;
      lock_err <= 1'b0;
    end else begin
      state <= next_state;
      lock_err <= (state == LOCKED) && (next_state == SEARCH);
    end
  always_comb
    next_state = (state == SEARCH) ? (vs_edge ? VERIFY : SEARCH)
               : (state == VERIFY) ? ((vs_edge && !flag && !line_bad && row == Y_W'(V_ACTIVE)) ? LOCKED : VERIFY)
               : (line_bad || (vs_edge && row != Y_W'(V_ACTIVE))) ? SEARCH : LOCKED;
  always_comb locked = state == LOCKED;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc;
  vga_crc16 u_crc (
    .clk(clk_dot),
    .rst(reset),
    .init(vs_edge),
    .en(s2_act),
    .data(s2_rgb),
    .crc(crc)
  );
  always_ff @(posedge clk_dot or posedge reset)
    if (reset) begin
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      frame_crc <= vs_edge ? crc : frame_crc;
      crc_valid <= vs_edge;
    end
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, expected active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, expected active lines per frame.
REQ-003 SHALL have parameter SYNC_POL, default 0, asserted level of vga_hsync and vga_vsync (0 = active-low).
REQ-004 SHALL have ports, clock and reset first: reset in 1 async active-high; clk_dot in 1 pixel clock (one clock, no other domains); vga_pixel_rgb in 12 incoming pixel; vga_active in 1 incoming data-enable; vga_hsync in 1; vga_vsync in 1.
REQ-005 SHALL have outputs: pix_valid 1 pixel strobe; pix_x 11 column; pix_y 10 row; pix_rgb 12 captured pixel; frame_start 1 one-cycle pulse; meas_h 11 last line width; meas_v 10 last frame height; locked 1; lock_err 1 one-cycle pulse; frame_crc 16; crc_valid 1 one-cycle pulse.

Function
REQ-006 SHALL register all video inputs once (stage S1) and detect edges by comparing S1 against a second register S2.
REQ-007 SHALL assert pix_valid exactly 2 clk_dot after vga_active is sampled high, with pix_rgb the pixel sampled on that same edge.
REQ-008 SHALL restart pix_x at 0 on each vga_active rising edge and increment per valid pixel, saturating at 2047.
REQ-009 SHALL increment pix_y on each vga_active falling edge, saturating at 1023; pix_y resets to 0 on the vsync asserting edge.
REQ-010 SHALL pulse frame_start for one cycle on the vsync asserting edge, aligned with pix_y reset.
REQ-011 SHALL latch meas_h = pixel count of the completed line on each vga_active falling edge.
REQ-012 SHALL latch meas_v = completed-line count on each vsync asserting edge.
REQ-013 SHALL keep a per-frame sticky mismatch flag, set when a completed line width != H_ACTIVE, cleared at frame_start.
REQ-014 SHALL implement lock FSM SEARCH/VERIFY/LOCKED: SEARCH->VERIFY on first vsync edge; VERIFY->LOCKED on vsync edge if flag clear and line count == V_ACTIVE, else remain VERIFY; LOCKED->SEARCH immediately on any mismatching line or on a vsync edge with line count != V_ACTIVE.
REQ-015 SHALL assert locked only in LOCKED and pulse lock_err for one cycle on every LOCKED->SEARCH transition.
REQ-016 SHALL treat a vsync edge arriving mid-line (vga_active high) as frame start: partial line discarded from meas_h, pix_x/pix_y restart.
REQ-017 SHALL ignore vga_hsync for counting; hsync is used only to confirm line boundaries (vga_active low at hsync edge; else set mismatch flag).
REQ-018 SHALL emit pix_valid regardless of lock state.

Reset
REQ-019 SHALL, on reset assertion, asynchronously clear S1/S2, all counters and strobes to 0, meas_h/meas_v to 0, frame_crc to 0, FSM to SEARCH.
REQ-020 SHALL, after reset release mid-frame, stay in SEARCH until the next vsync asserting edge.

Configuration
REQ-021 SHALL, with VGA_CAPTURE_CRC_EN defined, compute CRC-16-CCITT (poly 0x1021, init 0xFFFF, 12 bits per pixel MSB-first, one pixel per cycle) over valid pixels of each frame, latch it to frame_crc and pulse crc_valid on the vsync edge, then reinitialise.
REQ-022 SHALL, without VGA_CAPTURE_CRC_EN, tie frame_crc to 0 and crc_valid to 0 with no CRC logic synthesised.

Structure
REQ-023 SHALL take lock FSM state encoding, CRC polynomial/init constants and counter widths (11/10/12) from shared package vga_pkg used by vga_timing.
REQ-024 SHALL place the CRC update in sub-module vga_crc16 (combinational next-value plus register), instantiated only under VGA_CAPTURE_CRC_EN.

Verification (H_ACTIVE=8, V_ACTIVE=4, SYNC_POL=0)
REQ-025 SHALL check: drive vga_timing-style 8x4 frames -> pix_valid 2 cycles after vga_active, pix_x 0..7, pix_y 0..3, meas_h=8, meas_v=4.
REQ-026 SHALL check: three clean frames from reset -> SEARCH, VERIFY, locked high at the second vsync edge after reset.
REQ-027 SHALL check: while locked, one line of 7 pixels -> lock_err pulse and locked low at that line's active falling edge + 2 cycles.
REQ-028 SHALL check: vsync edge with vga_active high at pix_x=3 -> frame_start pulse, pix_x/pix_y restart at 0, meas_h unchanged.
REQ-029 SHALL check: reset asserted mid-line -> all outputs 0 within the same cycle, locked requires two full frames afterwards.
REQ-030 SHALL check, CRC enabled: frame of all pixels 0x000 -> frame_crc equals software model value, crc_valid one cycle at vsync edge.
